key_replay_tx: RTL and testbench
================================

# key_replay_tx

Transmit side of the keypad digit interface. Holds up to eight 4-bit digits loaded by a host, then on command replays them as a timed sequence of key presses on a `key`/`pressed` pair. The pair is shaped so a keypad digit-capture register can sit directly downstream and record the sequence. It serves as a test source and as an auto-dial/macro generator beside the keypad entry path.

## Interface
Parameters:
- PRESS_CYC, 4: clock cycles `pressed` is held high per digit (1..255)
- GAP_CYC, 4: clock cycles `pressed` is held low after each digit (1..255)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- clr  in  1  reset; one clock; reset is synchronous and active-low
- wr_en  in  1  write strobe for the digit store
- wr_sel  in  3  slot index to write (0..7)
- wr_data  in  4  digit value to write
- len  in  4  number of digits to replay; values 9..15 clamp to 8
- start  in  1  single-cycle request to begin replay
- abort  in  1  stops replay immediately
- key  out  4  digit currently presented
- pressed  out  1  press strobe toward the capture side
- busy  out  1  high while replay is in progress
- idx  out  3  slot currently being sent; 0 when idle
- done  out  1  one-cycle pulse when a replay completes normally

## Operation
- Reset (clr=0 at a clk edge):
  - All eight slots are cleared to 0.
  - State goes to IDLE.
  - key=0, pressed=0, busy=0, idx=0, done=0.
  - Reset wins over every other input, including mid-replay; no done pulse is produced.
- Digit store:
  - In IDLE, wr_en=1 writes wr_data into slot[wr_sel] at the clock edge.
  - While busy, wr_en is ignored and the slots are locked.
- FSM states: IDLE, PRESS, GAP.
  - IDLE:
    - start=1 with effective length L=min(len,8) ≥ 1 → PRESS. On entry idx=0, key=slot[0], pressed=1, busy=1, and the phase counter loads.
    - start=1 with len=0 → stays IDLE; done=1 for one cycle; no press.
  - PRESS: pressed=1 and key=slot[idx] for PRESS_CYC cycles, then → GAP.
  - GAP: pressed=0 and key holds slot[idx] for GAP_CYC cycles. Then:
    - if idx=L-1 → IDLE with done=1, busy=0, key=0, idx=0;
    - else idx+1 → PRESS.
- Send order: slot 0 first, slot L-1 last.
- The length L is latched at start; later changes to len have no effect on the running replay.
- start while busy is ignored.
- abort=1 in PRESS or GAP:
  - next cycle is IDLE; pressed=0, key=0, busy=0, idx=0;
  - no done pulse;
  - slots are untouched.
- abort in IDLE has no effect.
- abort and start asserted together in IDLE: abort is ignored and start is taken.
- Phase counter: 8-bit. Loads PRESS_CYC-1 or GAP_CYC-1 on phase entry, decrements to 0, and the phase ends on the cycle it reads 0.

## Timing
- All outputs are registered.
- start sampled at edge of cycle N:
  - pressed is high in cycles N+1 .. N+PRESS_CYC;
  - pressed is low in cycles N+PRESS_CYC+1 .. N+PRESS_CYC+GAP_CYC.
- Digit k (0-based) has its rising edge of `pressed` at cycle N+1+k·(PRESS_CYC+GAP_CYC).
- key changes only at the start of a PRESS phase. It is stable for the entire press and gap, so a capture side can sample it on pressed's rising edge.
- done and busy=0 appear at cycle N+L·(PRESS_CYC+GAP_CYC)+1.
- A new start is accepted in that same cycle.
- len=0: done is high in cycle N+1.
- abort sampled at cycle M: outputs are idle in cycle M+1.

## Test plan
- Write slots 0..7 = 1,2,..,8; len=8; PRESS_CYC=4, GAP_CYC=4; start at cycle 10 → eight pressed pulses, each 4 cycles wide, starting at cycles 11,19,..,67 with key=1..8; done high at cycle 75 only; busy high in cycles 11..74.
- len=3 after the same fill → keys 1,2,3 sent; done at start+25. Then len=12 → clamps to 8 digits.
- len=0, start → no pressed pulse; done high for exactly one cycle at start+1.
- Mid-replay, during the third PRESS: wr_en writing slot 0=0xF, a second start, and a change of len → all ignored; the sequence completes unchanged. Then abort during the fifth digit → pressed=0, busy=0 the next cycle; no done; slot contents still intact on replay.
- clr=0 asserted during a GAP phase → next cycle key=0, pressed=0, busy=0, idx=0; all slots read back 0 on a subsequent len=8 replay (eight key=0 presses).

Source files
------------

// File: rtl/key_replay_tx.sv
// Keypad digit replay source: holds eight 4-bit digits and plays them out as
// timed key presses on a key/pressed pair that a digit-capture register can sample.
module key_replay_tx #(
    parameter int PRESS_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [2:0] wr_sel,
    input  logic [3:0] wr_data,
    input  logic [3:0] len,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] key,
    output logic       pressed,
    output logic       busy,
    output logic [2:0] idx,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYC - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] idx_r, idx_s;
    logic [2:0] last_r, last_s;
    logic [3:0] key_r, key_s;
    logic       pressed_r, pressed_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic [3:0] slot_r [8];
    logic [3:0] eff_len_s;
    logic [2:0] next_idx_s;

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        last_s     = last_r;
        key_s      = key_r;
        pressed_s  = pressed_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        eff_len_s  = (len > 4'd8) ? 4'd8 : len;
        next_idx_s = idx_r + 3'd1;

        case (state_r)
            IDLE: begin
                // abort is deliberately not looked at here: start wins in IDLE
                if (start) begin
                    if (eff_len_s == 4'd0) begin
                        done_s = 1'b1;
                    end else begin
                        state_s   = PRESS;
                        cnt_s     = PRESS_LOAD;
                        idx_s     = 3'd0;
                        last_s    = 3'(eff_len_s - 4'd1);
                        key_s     = slot_r[0];
                        pressed_s = 1'b1;
                        busy_s    = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS: begin
                if (abort) begin
                    state_s   = IDLE;
                    idx_s     = 3'd0;
                    key_s     = 4'd0;
                    pressed_s = 1'b0;
                    busy_s    = 1'b0;
                end else if (cnt_r == 8'd0) begin
                    state_s   = GAP;
                    cnt_s     = GAP_LOAD;
                    pressed_s = 1'b0;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_s   = IDLE;
                    idx_s     = 3'd0;
                    key_s     = 4'd0;
                    pressed_s = 1'b0;
                    busy_s    = 1'b0;
                end else if (cnt_r != 8'd0) begin
                    cnt_s = cnt_r - 8'd1;
                end else if (idx_r == last_r) begin
                    state_s = IDLE;
                    idx_s   = 3'd0;
                    key_s   = 4'd0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s   = PRESS;
                    cnt_s     = PRESS_LOAD;
                    idx_s     = next_idx_s;
                    key_s     = slot_r[next_idx_s];
                    pressed_s = 1'b1;
                end
            end
            default: begin
                state_s   = IDLE;
                cnt_s     = 8'd0;
                idx_s     = 3'd0;
                key_s     = 4'd0;
                pressed_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Control and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            idx_r     <= 3'd0;
            last_r    <= 3'd0;
            key_r     <= 4'd0;
            pressed_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            last_r    <= last_s;
            key_r     <= key_s;
            pressed_r <= pressed_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Digit store: writable only while idle so a running replay cannot change.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 8; i++) begin
                slot_r[i] <= 4'd0;
            end
        end else if (wr_en && (state_r == IDLE)) begin
            slot_r[wr_sel] <= wr_data;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign key     = key_r;
    assign pressed = pressed_r;
    assign busy    = busy_r;
    assign idx     = idx_r;
    assign done    = done_r;

endmodule

// File: tb/tb_key_replay_tx.sv
// Scoreboard bench for key_replay_tx: stimulus queues expected press/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_key_replay_tx;

    localparam int P  = 4;
    localparam int G  = 4;
    localparam int PG = P + G;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_sel = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic [3:0] len = 4'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] key;
    logic       pressed;
    logic       busy;
    logic [2:0] idx;
    logic       done;

    typedef struct {
        logic       is_done;
        logic [3:0] key;
        int         cyc;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    logic       prev_pressed = 1'b0;
    logic [3:0] exp_slot [8];

    key_replay_tx #(.PRESS_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .len(len), .start(start), .abort(abort), .key(key), .pressed(pressed),
        .busy(busy), .idx(idx), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Monitor: every rising edge of pressed and every done cycle is one event.
    always @(negedge clk) begin
        if (pressed && !prev_pressed) begin
            if (q.size() == 0) check("unexpected_press", 1, 0);
            else begin
                ev_t e;
                e = q.pop_front();
                check("press_kind", 0, int'(e.is_done));
                check("press_key", int'(key), int'(e.key));
                check("press_cycle", cyc, e.cyc);
            end
        end
        if (done) begin
            if (q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                ev_t e;
                e = q.pop_front();
                check("done_kind", 1, int'(e.is_done));
                check("done_cycle", cyc, e.cyc);
            end
        end
        prev_pressed = pressed;
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a one-cycle start; queue npush press events and optionally the done.
    task automatic do_start(input logic [3:0] l, input int npush, input bit want_done,
                            output int n);
        int el;
        n = cyc;
        el = (l > 4'd8) ? 8 : int'(l);
        start = 1'b1;
        len = l;
        for (int k = 0; k < npush; k++)
            q.push_back('{1'b0, exp_slot[k], n + 1 + k * PG});
        if (want_done) q.push_back('{1'b1, 4'd0, n + el * PG + 1});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 300) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("drain_queue_empty", q.size(), 0);
        q.delete();
        repeat (6) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, n2;
        for (int i = 0; i < 8; i++) exp_slot[i] = 4'd0;
        goto(2);
        check("rst_key", int'(key), 0);
        check("rst_pressed", int'(pressed), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_done", int'(done), 0);
        clr = 1'b1;

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_sel = 3'(i);
            wr_data = 4'(i + 1);
            exp_slot[i] = 4'(i + 1);
            goto(3 + i);
        end
        wr_en = 1'b0;

        // full replay starting at cycle 10
        do_start(4'd8, 8, 1'b1, n);
        check("full_start_cycle", n, 10);
        check("busy_first", int'(busy), 1);
        check("idx_first", int'(idx), 0);
        check("key_first", int'(key), 1);
        goto(n + 9 + PG);
        check("idx_third", int'(idx), 2);
        goto(74);
        check("busy_last", int'(busy), 1);
        goto(75);
        check("busy_after", int'(busy), 0);
        check("key_after", int'(key), 0);
        drain();

        do_start(4'd3, 3, 1'b1, n);
        drain();
        do_start(4'd12, 8, 1'b1, n);
        drain();

        do_start(4'd0, 0, 1'b1, n);
        check("len0_busy", int'(busy), 0);
        check("len0_pressed", int'(pressed), 0);
        drain();

        // locked store, ignored start and len change during the third press
        do_start(4'd8, 8, 1'b1, n);
        goto(n + 18);
        wr_en = 1'b1; wr_sel = 3'd0; wr_data = 4'hF; start = 1'b1; len = 4'd2;
        goto(n + 19);
        wr_en = 1'b0; start = 1'b0; len = 4'd0;
        check("mid_busy", int'(busy), 1);
        drain();

        // abort during the fifth digit
        do_start(4'd8, 5, 1'b0, n);
        goto(n + 34);
        abort = 1'b1;
        goto(n + 35);
        abort = 1'b0;
        check("abort_pressed", int'(pressed), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_idx", int'(idx), 0);
        check("abort_key", int'(key), 0);
        drain();
        do_start(4'd8, 8, 1'b1, n);
        drain();

        // start with abort in idle is taken; restart in the done cycle
        abort = 1'b1;
        do_start(4'd1, 1, 1'b1, n);
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 1);
        goto(n + PG + 1);
        do_start(4'd2, 2, 1'b1, n2);
        drain();

        // clear during a gap wipes outputs and the store
        do_start(4'd8, 1, 1'b0, n);
        goto(n + 6);
        clr = 1'b0;
        goto(n + 7);
        clr = 1'b1;
        check("clr_key", int'(key), 0);
        check("clr_pressed", int'(pressed), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_idx", int'(idx), 0);
        for (int i = 0; i < 8; i++) exp_slot[i] = 4'd0;
        drain();
        do_start(4'd8, 8, 1'b1, n);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
